// File: rtl/wide_add_sequencer.sv
// Wide adder/subtractor built from one N-bit ripple slice reused across
// WORDS cycles, least significant word first.
module wide_add_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic               carry_in,
    input  logic [N*WORDS-1:0] A,
    input  logic [N*WORDS-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] sum,
    output logic               carry_out,
    output logic               overflow
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          load;
    logic          step;
    logic          last;
    logic [N-1:0]  wa;
    logic [N-1:0]  wb;
    logic [N-1:0]  ws;
    logic [N:0]    c;

    assign last = (idx == IW'(WORDS - 1));
    assign wa   = a_r[idx*N +: N];
    assign wb   = b_r[idx*N +: N];
    assign busy = (state == ADD);
    assign done = (state == DONE);

    // The single shared slice: a plain full-adder ripple chain.
    always_comb begin
        c    = '0;
        ws   = '0;
        c[0] = carry;
        for (int i = 0; i < N; i++) begin
            ws[i]   = wa[i] ^ wb[i] ^ c[i];
            c[i+1]  = (wa[i] & wb[i]) | (c[i] & (wa[i] ^ wb[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ADD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted once at capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (load) begin
            a_r   <= A;
            b_r   <= sub ? ~B : B;
            carry <= sub ? 1'b1 : carry_in;
            idx   <= '0;
        end else if (step) begin
            sum[idx*N +: N] <= ws;
            carry           <= c[N];
            idx             <= last ? '0 : idx + IW'(1);
            if (last) begin
                carry_out <= c[N];
                overflow  <= c[N-1] ^ c[N];
            end
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: a W+1-bit reference model
// predicts each result, checked when done pulses.
module tb_wide_add_sequencer;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         carry_in;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    exp_t q[$];
    int   checks;
    int   errors;

    wide_add_sequencer #(
        .N(N),
        .WORDS(WORDS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .sub(sub),
        .carry_in(carry_in),
        .A(A),
        .B(B),
        .busy(busy),
        .done(done),
        .sum(sum),
        .carry_out(carry_out),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic ci);
        logic [W-1:0] bb;
        logic [W:0]   r;
        exp_t         e;
        bb   = s ? ~b : b;
        r    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        e.s  = r[W-1:0];
        e.co = r[W];
        e.ov = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    // Called away from a clock edge; returns just after the capture edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci, input bit push);
        A        = a;
        B        = b;
        sub      = s;
        carry_in = ci;
        start    = 1'b1;
        if (push) q.push_back(model(a, b, s, ci));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit disturb);
        int   n;
        int   nb;
        bit   seen;
        exp_t e;
        n    = 0;
        nb   = 0;
        seen = 0;
        while (!seen && n < 3 * WORDS + 4) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) seen = 1;
            if (disturb && n == 2) begin
                start    = 1'b1;
                A        = $urandom;
                B        = $urandom;
                sub      = 1'b1;
                carry_in = 1'b0;
            end
            if (disturb && n == 3) start = 1'b0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
            if (q.size() > 0) void'(q.pop_front());
            return;
        end
        checks++;
        if (n !== WORDS + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, n, WORDS + 1);
        end
        checks++;
        if (nb !== WORDS) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, nb, WORDS);
        end
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: done with no expected entry", name);
        end else begin
            e = q.pop_front();
            if ({sum, carry_out, overflow} !== {e.s, e.co, e.ov}) begin
                errors++;
                $display("FAIL %s result: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                         name, sum, carry_out, overflow, e.s, e.co, e.ov);
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        sub      = 1'b0;
        carry_in = 1'b1;
        A        = 32'hDEADBEEF;
        B        = 32'h12345678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, sum, carry_out, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h co=%b ov=%b required all 0",
                     busy, done, sum, carry_out, overflow);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_carry_chain();
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
        wait_done("add_carry", 1'b0);
    endtask

    task automatic test_sub();
        @(negedge clk);
        issue(32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b1);
        wait_done("sub_borrow", 1'b0);
    endtask

    task automatic test_overflow();
        @(negedge clk);
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
        wait_done("add_ovf", 1'b0);
        @(negedge clk);
        issue(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1);
        wait_done("sub_ovf", 1'b0);
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b1);
        wait_done("ignore_start", 1'b1);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_start_single_done: got busy=%b done=%b required 0 0",
                     busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        @(negedge clk);
        issue(32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, sum, carry_out, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b sum=%h co=%b ov=%b required all 0",
                     busy, done, sum, carry_out, overflow);
        end
        rst_n = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d active cycles required 0", dn);
        end
        issue(32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b1);
        wait_done("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] prev;
        @(negedge clk);
        issue(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 1'b1);
        wait_done("b2b_first", 1'b0);
        prev = sum;
        issue(32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1 || sum !== prev) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b sum=%h required busy=1 sum=%h",
                     busy, sum, prev);
        end
        wait_done("b2b_second", 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            wait_done("random", 1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        carry_in = 1'b0;
        A        = '0;
        B        = '0;
        test_reset();
        test_carry_chain();
        test_sub();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
